// File: rtl/instr_decode_stage_pkg.sv
// Types shared by the integer-ALU decode stage: opcodes, funct7 values, decoded-instruction layout.
package instr_decode_stage_pkg;

  parameter int XLEN = 32;

  typedef logic [XLEN-1:0] t_word;
  typedef logic [4:0]      t_reg_idx;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b00_100_11;
  localparam logic [6:0] OPCODE_OP     = 7'b01_100_11;
  localparam logic [6:0] F7_BASE       = 7'b0000000;
  localparam logic [6:0] F7_ALT        = 7'b0100000;

  typedef enum logic [1:0] {
    OK_UNKNOWN = 2'd0,
    OK_OP_IMM  = 2'd1,
    OK_OP      = 2'd2
  } t_op_kind;

  typedef enum logic [3:0] {
    FK_ADD, FK_SUB, FK_SLT, FK_SLTU, FK_XOR, FK_OR, FK_AND, FK_SLL, FK_SRL, FK_SRA
  } t_func_kind;

  typedef struct packed {
    t_func_kind func;
    t_reg_idx   src;
    t_reg_idx   dest;
    t_word      imm;
  } t_op_imm_instr;

  typedef struct packed {
    t_func_kind func;
    t_reg_idx   src1;
    t_reg_idx   src2;
    t_reg_idx   dest;
  } t_op_reg_instr;

  localparam int OP_REG_PAD = $bits(t_op_imm_instr) - $bits(t_op_reg_instr);

  typedef struct packed {
    t_op_reg_instr         op;
    logic [OP_REG_PAD-1:0] pad;
  } t_op_reg_padded;

  typedef union packed {
    t_op_imm_instr  op_imm;
    t_op_reg_padded op_reg;
  } t_instr_data_union;

  typedef struct packed {
    t_op_kind          kind;
    t_instr_data_union instr_data;
  } t_decoded_instr;

  // funct3 meaning shared by OP_IMM and the base-funct7 OP encodings
  function automatic t_func_kind f3_base_func(input logic [2:0] f3);
    case (f3)
      3'b000:  return FK_ADD;
      3'b001:  return FK_SLL;
      3'b010:  return FK_SLT;
      3'b011:  return FK_SLTU;
      3'b100:  return FK_XOR;
      3'b101:  return FK_SRL;
      3'b110:  return FK_OR;
      default: return FK_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_stage_comb.sv
// Combinational decode of one instruction word into t_decoded_instr plus an illegal flag.
module instr_decode_comb
  import instr_decode_stage_pkg::*;
#(
  parameter int XLEN       = instr_decode_stage_pkg::XLEN,
  parameter bit SUPPORT_OP = 1'b1
) (
  input  logic [31:0]    instr,
  output t_decoded_instr decoded,
  output logic           illegal
);

  localparam int W = $bits(t_word);

  logic [6:0]     opcode;
  logic [6:0]     funct7;
  logic [2:0]     funct3;
  logic [5:0]     shamt;
  logic           shamt_bad;
  logic           legal;
  t_decoded_instr dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    if (XLEN == 64) begin
      shamt     = instr[25:20];
      shamt_bad = 1'b0;
    end else begin
      shamt     = {1'b0, instr[24:20]};
      shamt_bad = instr[25];
    end
    case (opcode)
      OPCODE_OP_IMM: begin
        legal                       = 1'b1;
        dec.kind                    = OK_OP_IMM;
        dec.instr_data.op_imm.func  = f3_base_func(funct3);
        dec.instr_data.op_imm.src   = instr[19:15];
        dec.instr_data.op_imm.dest  = instr[11:7];
        dec.instr_data.op_imm.imm   = {{(W-12){instr[31]}}, instr[31:20]};
        if (funct3 == 3'b001) begin
          dec.instr_data.op_imm.imm = t_word'(shamt);
          legal = (instr[31:26] == 6'b0) && !shamt_bad;
        end else if (funct3 == 3'b101) begin
          // bit 30 selects arithmetic shift; the rest of the upper field must be clear
          dec.instr_data.op_imm.imm = t_word'(shamt);
          legal = ({instr[31], instr[29:26]} == 5'b0) && !shamt_bad;
          if (instr[30]) dec.instr_data.op_imm.func = FK_SRA;
        end
      end
      OPCODE_OP: begin
        if (SUPPORT_OP) begin
          dec.kind                      = OK_OP;
          dec.instr_data.op_reg.op.func = f3_base_func(funct3);
          dec.instr_data.op_reg.op.src1 = instr[19:15];
          dec.instr_data.op_reg.op.src2 = instr[24:20];
          dec.instr_data.op_reg.op.dest = instr[11:7];
          if (funct7 == F7_BASE) begin
            legal = 1'b1;
          end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
            legal = 1'b1;
            dec.instr_data.op_reg.op.func = FK_SUB;
          end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
            legal = 1'b1;
            dec.instr_data.op_reg.op.func = FK_SRA;
          end
        end
      end
      default: ;
    endcase
  end

  assign illegal = !legal;
  assign decoded = legal ? dec : '0;

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: 1-cycle latency, output register plus one skid entry.
// in_ready comes straight from a flop (skid empty), so a stalled execute fills the skid first.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int XLEN       = instr_decode_stage_pkg::XLEN,
  parameter bit SUPPORT_OP = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_instr,
  output logic           out_valid,
  input  logic           out_ready,
  output t_decoded_instr out_decoded,
  output logic           out_illegal
);

  t_decoded_instr dec;
  logic           dec_illegal;
  logic           accept;
  logic           out_free;

  logic           out_valid_q,   out_valid_d;
  logic           out_illegal_q, out_illegal_d;
  t_decoded_instr out_dec_q,     out_dec_d;
  logic           skid_valid_q,  skid_valid_d;
  logic           skid_illegal_q, skid_illegal_d;
  t_decoded_instr skid_dec_q,    skid_dec_d;

  instr_decode_comb #(
    .XLEN       (XLEN),
    .SUPPORT_OP (SUPPORT_OP)
  ) u_decode (
    .instr   (in_instr),
    .decoded (dec),
    .illegal (dec_illegal)
  );

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && !skid_valid_q;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_illegal_d  = out_illegal_q;
    out_dec_d      = out_dec_q;
    skid_valid_d   = skid_valid_q;
    skid_illegal_d = skid_illegal_q;
    skid_dec_d     = skid_dec_q;
    if (out_free) begin
      // skid is older than anything on the input, so it always refills the output first
      if (skid_valid_q) begin
        out_valid_d   = 1'b1;
        out_dec_d     = skid_dec_q;
        out_illegal_d = skid_illegal_q;
        skid_valid_d  = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_dec_d     = dec;
          out_illegal_d = dec_illegal;
        end
      end
    end else if (accept) begin
      skid_valid_d   = 1'b1;
      skid_dec_d     = dec;
      skid_illegal_d = dec_illegal;
    end
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_illegal_q  <= 1'b0;
      out_dec_q      <= '0;
      skid_valid_q   <= 1'b0;
      skid_illegal_q <= 1'b0;
      skid_dec_q     <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_illegal_q  <= out_illegal_d;
      out_dec_q      <= out_dec_d;
      skid_valid_q   <= skid_valid_d;
      skid_illegal_q <= skid_illegal_d;
      skid_dec_q     <= skid_dec_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_illegal = out_illegal_q;
  assign out_decoded = out_dec_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode vectors, backpressure, streaming, flush and reset.
module tb_instr_decode_stage;
  import instr_decode_stage_pkg::*;

  logic           clk = 1'b0;
  logic           reset, flush, in_valid, out_ready;
  logic [31:0]    in_instr;
  logic           in_ready, out_valid, out_illegal;
  t_decoded_instr out_decoded;
  logic           nop_in_ready, nop_out_valid, nop_out_illegal;
  t_decoded_instr nop_out_decoded;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(32), .SUPPORT_OP(1'b1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_decoded(out_decoded), .out_illegal(out_illegal)
  );

  instr_decode_stage #(.XLEN(32), .SUPPORT_OP(1'b0)) u_dut_noop (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(nop_in_ready),
    .in_instr(in_instr), .out_valid(nop_out_valid), .out_ready(out_ready),
    .out_decoded(nop_out_decoded), .out_illegal(nop_out_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic t_decoded_instr exp_imm(input t_func_kind f, input logic [4:0] s,
                                             input logic [4:0] d, input t_word imm);
    t_decoded_instr r;
    r = '0;
    r.kind = OK_OP_IMM;
    r.instr_data.op_imm.func = f;
    r.instr_data.op_imm.src  = s;
    r.instr_data.op_imm.dest = d;
    r.instr_data.op_imm.imm  = imm;
    return r;
  endfunction

  function automatic t_decoded_instr exp_reg(input t_func_kind f, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic [4:0] d);
    t_decoded_instr r;
    r = '0;
    r.kind = OK_OP;
    r.instr_data.op_reg.op.func = f;
    r.instr_data.op_reg.op.src1 = s1;
    r.instr_data.op_reg.op.src2 = s2;
    r.instr_data.op_reg.op.dest = d;
    return r;
  endfunction

  function automatic logic [31:0] stream_word(input int i);
    return {i[11:0], 5'd0, 3'b000, i[4:0], 7'b0010011};
  endfunction

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    checks++; if (out_decoded !== '0) begin errors++; $display("FAIL reset_out_decoded: got %h, expected 0", out_decoded); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_out_illegal: got %b, expected 0", out_illegal); end
    checks++; if (nop_in_ready !== 1'b1) begin errors++; $display("FAIL reset_nop_in_ready: got %b, expected 1", nop_in_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    issue(32'hFFF10093);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b, expected 1", out_valid); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal: got %b, expected 0", out_illegal); end
    checks++; if (out_decoded !== exp_imm(FK_ADD, 5'd2, 5'd1, 32'hFFFFFFFF))
      begin errors++; $display("FAIL addi_decoded: got %h, expected %h", out_decoded, exp_imm(FK_ADD, 5'd2, 5'd1, 32'hFFFFFFFF)); end
    tick();
  endtask

  task automatic test_shift();
    out_ready = 1'b1;
    issue(32'h41F1D193);
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL srai_illegal: got %b, expected 0", out_illegal); end
    checks++; if (out_decoded !== exp_imm(FK_SRA, 5'd3, 5'd3, 32'd31))
      begin errors++; $display("FAIL srai_decoded: got %h, expected %h", out_decoded, exp_imm(FK_SRA, 5'd3, 5'd3, 32'd31)); end
    issue(32'h43F1D193);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL srai_bit25_valid: got %b, expected 1", out_valid); end
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL srai_bit25_illegal: got %b, expected 1", out_illegal); end
    checks++; if (out_decoded !== '0) begin errors++; $display("FAIL srai_bit25_decoded: got %h, expected 0", out_decoded); end
    issue(32'h0031D193);
    checks++; if (out_decoded !== exp_imm(FK_SRL, 5'd3, 5'd3, 32'd3))
      begin errors++; $display("FAIL srli_decoded: got %h, expected %h", out_decoded, exp_imm(FK_SRL, 5'd3, 5'd3, 32'd3)); end
    tick();
  endtask

  task automatic test_op();
    out_ready = 1'b1;
    issue(32'h407302B3);
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL sub_illegal: got %b, expected 0", out_illegal); end
    checks++; if (out_decoded !== exp_reg(FK_SUB, 5'd6, 5'd7, 5'd5))
      begin errors++; $display("FAIL sub_decoded: got %h, expected %h", out_decoded, exp_reg(FK_SUB, 5'd6, 5'd7, 5'd5)); end
    checks++; if (nop_out_valid !== 1'b1) begin errors++; $display("FAIL sub_noop_valid: got %b, expected 1", nop_out_valid); end
    checks++; if (nop_out_illegal !== 1'b1) begin errors++; $display("FAIL sub_noop_illegal: got %b, expected 1", nop_out_illegal); end
    checks++; if (nop_out_decoded !== '0) begin errors++; $display("FAIL sub_noop_decoded: got %h, expected 0", nop_out_decoded); end
    issue(32'h007302B3);
    checks++; if (out_decoded !== exp_reg(FK_ADD, 5'd6, 5'd7, 5'd5))
      begin errors++; $display("FAIL add_decoded: got %h, expected %h", out_decoded, exp_reg(FK_ADD, 5'd6, 5'd7, 5'd5)); end
    issue(32'h407372B3);
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL alt_and_illegal: got %b, expected 1", out_illegal); end
    checks++; if (out_decoded !== '0) begin errors++; $display("FAIL alt_and_decoded: got %h, expected 0", out_decoded); end
    issue(32'h00000073);
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL system_illegal: got %b, expected 1", out_illegal); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(32'h00100093);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a: got %b, expected 1", in_ready); end
    checks++; if (out_decoded !== exp_imm(FK_ADD, 5'd0, 5'd1, 32'd1))
      begin errors++; $display("FAIL bp_out_a: got %h, expected %h", out_decoded, exp_imm(FK_ADD, 5'd0, 5'd1, 32'd1)); end
    issue(32'h00200113);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b: got %b, expected 0", in_ready); end
    in_valid = 1'b1; in_instr = 32'h00300193;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b, expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_full: got %b, expected 1", out_valid); end
    checks++; if (out_decoded !== exp_imm(FK_ADD, 5'd0, 5'd1, 32'd1))
      begin errors++; $display("FAIL bp_out_stable: got %h, expected %h", out_decoded, exp_imm(FK_ADD, 5'd0, 5'd1, 32'd1)); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid: got %b, expected 1", out_valid); end
    checks++; if (out_decoded !== exp_imm(FK_ADD, 5'd0, 5'd2, 32'd2))
      begin errors++; $display("FAIL bp_drain_b: got %h, expected %h", out_decoded, exp_imm(FK_ADD, 5'd0, 5'd2, 32'd2)); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_again: got %b, expected 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b, expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int  sent = 0;
    int  got = 0;
    int  bubbles = 0;
    bit  started = 1'b0;
    bit  hs;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 130 && got < 100; cyc++) begin
      in_valid = (sent < 100);
      in_instr = stream_word(sent);
      hs = in_valid && in_ready;
      tick();
      if (hs) sent++;
      if (out_valid === 1'b1) begin
        checks++;
        if (out_decoded !== exp_imm(FK_ADD, 5'd0, got[4:0], t_word'(got))) begin
          errors++;
          $display("FAIL stream_word_%0d: got %h, expected %h", got, out_decoded, exp_imm(FK_ADD, 5'd0, got[4:0], t_word'(got)));
        end
        got++;
        started = 1'b1;
      end else if (started) begin
        bubbles++;
      end
    end
    in_valid = 1'b0;
    checks++; if (got != 100) begin errors++; $display("FAIL stream_count: got %0d, expected 100", got); end
    checks++; if (bubbles != 0) begin errors++; $display("FAIL stream_bubbles: got %0d, expected 0", bubbles); end
    tick();
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b0;
    issue(32'h00100093);
    issue(32'h00200113);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefill_ready: got %b, expected 0", in_ready); end
    in_valid = 1'b1; in_instr = 32'h00300193; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b, expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b, expected 1", in_ready); end
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_ghost_outputs: got %0d, expected 0", seen); end
    in_valid = 1'b1; in_instr = 32'h00100093; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_same_cycle_drop: got %b, expected 0", out_valid); end
    out_ready = 1'b0;
    issue(32'h00100093);
    issue(32'h00200113);
    in_valid = 1'b1; in_instr = 32'h00300193; reset = 1'b1;
    tick();
    in_valid = 1'b0; reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b, expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b, expected 1", in_ready); end
    checks++; if (out_decoded !== '0) begin errors++; $display("FAIL midreset_decoded: got %h, expected 0", out_decoded); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_shift();
    test_op();
    test_backpressure();
    test_back_to_back();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
